riscv_instr_mem_responder: RTL and testbench
============================================

# riscv_instr_mem_responder

Memory-side responder for the core's instruction fetch interface (req/gnt/rvalid/rdata/err_pmp). It accepts fetch requests from the prefetch buffer, reads an internal instruction array, and returns in-order responses after a fixed, parameterised latency. It also flags a PMP-style error for out-of-range addresses and exposes a preload write port. It sits between the IF stage and the instruction memory, and serves as both the simulation memory model and the L2 instruction port shim.

## Interface
- RDATA_WIDTH, 32, word width in bits; 32 or 40 (40 carries CFI tag bits).
- DEPTH, 4096, number of words in the array.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- LATENCY, 1, cycles from grant to rvalid; legal range 1..4.
- MAX_OUTSTANDING, 2, maximum number of granted requests not yet answered; legal range 1..LATENCY+1.

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  byte address; bits [1:0] ignored
- instr_gnt_o  out  1  request accepted this cycle
- instr_rvalid_o  out  1  response valid, one cycle per granted request
- instr_rdata_o  out  RDATA_WIDTH  response data
- instr_err_pmp_o  out  1  response is an access fault; qualified by rvalid
- stall_i  in  1  backpressure injection; suppresses grant
- load_we_i  in  1  preload write enable
- load_addr_i  in  $clog2(DEPTH)  preload word index
- load_wdata_i  in  RDATA_WIDTH  preload data
- busy_o  out  1  at least one request outstanding

## Operation
- Grant rule (combinational): instr_gnt_o = instr_req_i & rst_n & ~stall_i & ~load_we_i & (cnt < MAX_OUTSTANDING | instr_rvalid_o).
- A request is accepted on a rising edge where req & gnt. The initiator holds the address stable while req & ~gnt. The responder does not check this.
- On accept, the word index is (addr - BASE_ADDR) >> 2. The array is read and the result enters pipeline stage 0 as {valid, err, data}. Data is therefore captured at accept time; later preload writes do not alter in-flight responses.
- Range check: addr < BASE_ADDR or addr >= BASE_ADDR + 4*DEPTH gives err=1 and data=0. The array is not read for these requests.
- The pipeline is a shift register of depth LATENCY. The last stage drives instr_rvalid_o, instr_rdata_o and instr_err_pmp_o directly from flops.
- When no response is valid, instr_rdata_o and instr_err_pmp_o are 0.
- Outstanding counter cnt, width $clog2(MAX_OUTSTANDING+1):
  - accept only: +1
  - rvalid only: -1
  - both, or neither: unchanged
- cnt never exceeds MAX_OUTSTANDING and never underflows.
- busy_o = (cnt != 0).
- Preload: load_we_i writes load_wdata_i to array[load_addr_i] on the rising edge. Load has priority over fetch, so grant is 0 in that cycle.
- The array is not reset.

## Timing
- Reset (async assert, sync release):
  - instr_rvalid_o=0, instr_rdata_o=0, instr_err_pmp_o=0, busy_o=0, cnt=0, all pipeline stages invalid.
  - instr_gnt_o=0 while rst_n=0.
- Reset asserted mid-operation discards all in-flight responses. No rvalid appears for requests granted before reset.
- Grant is same-cycle as req (zero-latency accept).
- Request accepted at edge T: rvalid is high in the cycle following edge T+LATENCY-1, i.e. exactly LATENCY cycles after the accept cycle, for exactly one cycle.
- Responses are strictly in acceptance order.
- Throughput:
  - 1 request/cycle when MAX_OUTSTANDING >= LATENCY.
  - Otherwise grant drops until the oldest response retires. Grant is allowed in the retiring cycle.
- Preload write at edge T is visible to a request accepted at edge T+1 or later.
- stall_i affects grant only. Outstanding responses still return on schedule.

## Test plan
- Preload word0=32'h0000_0413, word1=32'h0040_0493 (LATENCY=1); req addr 0x0 -> gnt in same cycle; next cycle rvalid=1, rdata=32'h0000_0413, err=0.
- LATENCY=2, MAX_OUTSTANDING=2; req held for 4 cycles with addr 0x0,0x4,0x8,0xC -> gnt in all 4 cycles; rvalid in 4 consecutive cycles starting 2 cycles after the first accept, data in order; busy_o high throughout, then 0.
- LATENCY=2, MAX_OUTSTANDING=1; req held with 0x0 then 0x4 -> gnt=1 at T, gnt=0 at T+1, gnt=1 at T+2 (coincides with rvalid for 0x0); cnt stays 1.
- req addr BASE_ADDR+4*DEPTH (0x4000 at defaults) -> gnt=1; rvalid with err_pmp=1, rdata=0; next request to 0x4 returns normally with err=0.
- stall_i=1 for 3 cycles with req high at addr 0x8 -> gnt=0 and no rvalid for 3 cycles; gnt=1 in the cycle stall_i drops; one response for 0x8. Repeat with load_we_i in place of stall_i -> same grant suppression, and the written word is readable one cycle later.
- Two requests in flight (LATENCY=3), assert rst_n=0 for 1 cycle -> all outputs 0 immediately; no rvalid after release; cnt=0; the first post-reset req is granted in the same cycle.

Source files
------------

// File: rtl/riscv_instr_mem_responder.sv
// Instruction-fetch memory responder: zero-latency grant, fixed-latency in-order
// responses, out-of-range access fault, and a preload write port.
module riscv_instr_mem_responder #(
  parameter int unsigned RDATA_WIDTH     = 32,
  parameter int unsigned DEPTH           = 4096,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       instr_req_i,
  input  logic [31:0]                instr_addr_i,
  output logic                       instr_gnt_o,
  output logic                       instr_rvalid_o,
  output logic [RDATA_WIDTH-1:0]     instr_rdata_o,
  output logic                       instr_err_pmp_o,
  input  logic                       stall_i,
  input  logic                       load_we_i,
  input  logic [$clog2(DEPTH)-1:0]   load_addr_i,
  input  logic [RDATA_WIDTH-1:0]     load_wdata_i,
  output logic                       busy_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [32:0] LIMIT = 33'(BASE_ADDR) + 33'(4 * DEPTH);

  logic [RDATA_WIDTH-1:0] mem_q [DEPTH];

  logic [LATENCY-1:0]                  vld_q, vld_d;
  logic [LATENCY-1:0]                  err_q, err_d;
  logic [LATENCY-1:0][RDATA_WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]                       cnt_q, cnt_d;
  logic                                busy_q, busy_d;

  logic          accept;
  logic          in_range;
  logic [AW-1:0] idx;

  assign instr_rvalid_o  = vld_q[LATENCY-1];
  assign instr_err_pmp_o = err_q[LATENCY-1];
  assign instr_rdata_o   = data_q[LATENCY-1];
  assign busy_o          = busy_q;

  // Retiring response frees a slot in the same cycle, keeping full throughput.
  assign instr_gnt_o = instr_req_i & rst_n & ~stall_i & ~load_we_i &
                       ((cnt_q < CW'(MAX_OUTSTANDING)) | instr_rvalid_o);
  assign accept      = instr_req_i & instr_gnt_o;

  assign in_range = ({1'b0, instr_addr_i} >= 33'(BASE_ADDR)) && ({1'b0, instr_addr_i} < LIMIT);
  assign idx      = AW'((instr_addr_i - BASE_ADDR) >> 2);

  // Preload port; array contents survive reset.
  always_ff @(posedge clk) begin
    if (load_we_i) begin
      mem_q[load_addr_i] <= load_wdata_i;
    end
  end

  always_comb begin
    vld_d  = '0;
    err_d  = '0;
    data_d = '0;
    cnt_d  = cnt_q;

    for (int i = LATENCY - 1; i > 0; i--) begin
      vld_d[i]  = vld_q[i-1];
      err_d[i]  = err_q[i-1];
      data_d[i] = data_q[i-1];
    end

    // Data is captured at accept so later preloads cannot alter in-flight words.
    vld_d[0]  = accept;
    err_d[0]  = accept & ~in_range;
    data_d[0] = (accept && in_range) ? mem_q[idx] : '0;

    case ({accept, instr_rvalid_o})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      err_q  <= '0;
      data_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      err_q  <= err_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_riscv_instr_mem_responder.sv
// Directed bench: four responder instances (different LATENCY / MAX_OUTSTANDING)
// share one stimulus bus; each scenario checks the instance it targets.
module tb_riscv_instr_mem_responder;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        stall;
  logic        we;
  logic [11:0] la;
  logic [31:0] wd;

  logic [3:0]  gnt, rvalid, err, busy;
  logic [31:0] rdata [4];

  int n_vec = 0;
  int n_bad = 0;

  riscv_instr_mem_responder #(.LATENCY(1), .MAX_OUTSTANDING(2)) u_l1 (
    .clk(clk), .rst_n(rst_n), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt[0]), .instr_rvalid_o(rvalid[0]), .instr_rdata_o(rdata[0]),
    .instr_err_pmp_o(err[0]), .stall_i(stall), .load_we_i(we), .load_addr_i(la),
    .load_wdata_i(wd), .busy_o(busy[0]));

  riscv_instr_mem_responder #(.LATENCY(2), .MAX_OUTSTANDING(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt[1]), .instr_rvalid_o(rvalid[1]), .instr_rdata_o(rdata[1]),
    .instr_err_pmp_o(err[1]), .stall_i(stall), .load_we_i(we), .load_addr_i(la),
    .load_wdata_i(wd), .busy_o(busy[1]));

  riscv_instr_mem_responder #(.LATENCY(2), .MAX_OUTSTANDING(1)) u_l2m1 (
    .clk(clk), .rst_n(rst_n), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt[2]), .instr_rvalid_o(rvalid[2]), .instr_rdata_o(rdata[2]),
    .instr_err_pmp_o(err[2]), .stall_i(stall), .load_we_i(we), .load_addr_i(la),
    .load_wdata_i(wd), .busy_o(busy[2]));

  riscv_instr_mem_responder #(.LATENCY(3), .MAX_OUTSTANDING(2)) u_l3 (
    .clk(clk), .rst_n(rst_n), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt[3]), .instr_rvalid_o(rvalid[3]), .instr_rdata_o(rdata[3]),
    .instr_err_pmp_o(err[3]), .stall_i(stall), .load_we_i(we), .load_addr_i(la),
    .load_wdata_i(wd), .busy_o(busy[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          req;
    logic [31:0] addr;
    bit          stall;
    bit          we;
    logic [11:0] la;
    logic [31:0] wd;
    bit          gnt;
    bit          rv;
    logic [31:0] rdata;
    bit          err;
    bit          busy;
  } vec_t;

  vec_t tbl [27];

  function automatic vec_t v(input bit rq, input logic [31:0] a, input bit st, input bit w,
                             input logic [11:0] l, input logic [31:0] d, input bit eg,
                             input bit erv, input logic [31:0] erd, input bit eer, input bit eby);
    vec_t r;
    r.req = rq; r.addr = a; r.stall = st; r.we = w; r.la = l; r.wd = d;
    r.gnt = eg; r.rv = erv; r.rdata = erd; r.err = eer; r.busy = eby;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input int k, input string nm, input bit eg, input bit erv,
                         input logic [31:0] erd, input bit eer, input bit eby);
    chk({nm, ".gnt"},    32'(gnt[k]),    32'(eg));
    chk({nm, ".rvalid"}, 32'(rvalid[k]), 32'(erv));
    chk({nm, ".rdata"},  rdata[k],       erd);
    chk({nm, ".err"},    32'(err[k]),    32'(eer));
    chk({nm, ".busy"},   32'(busy[k]),   32'(eby));
  endtask

  // One cycle: drive at posedge+1, check at negedge, return at next posedge+1.
  task automatic cyc(input int k, input string nm, input bit rq, input logic [31:0] a,
                     input bit eg, input bit erv, input logic [31:0] erd,
                     input bit eer, input bit eby);
    req = rq; addr = a; stall = L; we = L; la = '0; wd = '0;
    @(negedge clk);
    chk_all(k, nm, eg, erv, erd, eer, eby);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    req = L; addr = '0; stall = L; we = L; la = '0; wd = '0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    //           req addr          st we la       wd             g  rv rdata          er by
    tbl[0]  = v(H, 32'h0000_0000, L, H, 12'd0,   32'h0000_0413, L, L, 32'h0,          L, L);
    tbl[1]  = v(L, 32'h0000_0000, L, H, 12'd1,   32'h0040_0493, L, L, 32'h0,          L, L);
    tbl[2]  = v(L, 32'h0000_0000, L, H, 12'd2,   32'h0000_0013, L, L, 32'h0,          L, L);
    tbl[3]  = v(L, 32'h0000_0000, L, H, 12'd3,   32'h1111_2222, L, L, 32'h0,          L, L);
    tbl[4]  = v(H, 32'h0000_0000, L, L, 12'd0,   32'h0,         H, L, 32'h0,          L, L);
    tbl[5]  = v(H, 32'h0000_0004, L, L, 12'd0,   32'h0,         H, H, 32'h0000_0413, L, H);
    tbl[6]  = v(H, 32'h0000_4000, L, L, 12'd0,   32'h0,         H, H, 32'h0040_0493, L, H);
    tbl[7]  = v(H, 32'h0000_0004, L, L, 12'd0,   32'h0,         H, H, 32'h0,          H, H);
    tbl[8]  = v(L, 32'h0000_0000, L, L, 12'd0,   32'h0,         L, H, 32'h0040_0493, L, H);
    tbl[9]  = v(L, 32'h0000_0000, L, L, 12'd0,   32'h0,         L, L, 32'h0,          L, L);
    tbl[10] = v(H, 32'h0000_0008, H, L, 12'd0,   32'h0,         L, L, 32'h0,          L, L);
    tbl[11] = v(H, 32'h0000_0008, H, L, 12'd0,   32'h0,         L, L, 32'h0,          L, L);
    tbl[12] = v(H, 32'h0000_0008, H, L, 12'd0,   32'h0,         L, L, 32'h0,          L, L);
    tbl[13] = v(H, 32'h0000_0008, L, L, 12'd0,   32'h0,         H, L, 32'h0,          L, L);
    tbl[14] = v(L, 32'h0000_0000, L, L, 12'd0,   32'h0,         L, H, 32'h0000_0013, L, H);
    tbl[15] = v(L, 32'h0000_0000, L, L, 12'd0,   32'h0,         L, L, 32'h0,          L, L);
    tbl[16] = v(H, 32'h0000_000C, L, H, 12'd3,   32'hCAFE_F00D, L, L, 32'h0,          L, L);
    tbl[17] = v(H, 32'h0000_000C, L, H, 12'd3,   32'hCAFE_F00D, L, L, 32'h0,          L, L);
    tbl[18] = v(H, 32'h0000_000C, L, H, 12'd3,   32'hCAFE_F00D, L, L, 32'h0,          L, L);
    tbl[19] = v(H, 32'h0000_000C, L, L, 12'd0,   32'h0,         H, L, 32'h0,          L, L);
    tbl[20] = v(L, 32'h0000_0000, L, L, 12'd0,   32'h0,         L, H, 32'hCAFE_F00D, L, H);
    tbl[21] = v(H, 32'h0000_0007, L, L, 12'd0,   32'h0,         H, L, 32'h0,          L, L);
    tbl[22] = v(L, 32'h0000_0000, L, H, 12'hFFF, 32'hDEAD_BEEF, L, H, 32'h0040_0493, L, H);
    tbl[23] = v(H, 32'h0000_3FFC, L, L, 12'd0,   32'h0,         H, L, 32'h0,          L, L);
    tbl[24] = v(H, 32'h0000_4000, L, L, 12'd0,   32'h0,         H, H, 32'hDEAD_BEEF, L, H);
    tbl[25] = v(L, 32'h0000_0000, L, L, 12'd0,   32'h0,         L, H, 32'h0,          H, H);
    tbl[26] = v(L, 32'h0000_0000, L, L, 12'd0,   32'h0,         L, L, 32'h0,          L, L);

    rst_n = 1'b0; req = H; addr = '0; stall = L; we = L; la = '0; wd = '0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk_all(k, $sformatf("reset%0d", k), L, L, 32'h0, L, L);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 27; i++) begin
      req = tbl[i].req; addr = tbl[i].addr; stall = tbl[i].stall;
      we = tbl[i].we; la = tbl[i].la; wd = tbl[i].wd;
      @(negedge clk);
      chk_all(0, $sformatf("v%0d", i), tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].err, tbl[i].busy);
      @(posedge clk); #1;
    end
    idle(5);

    // LATENCY=2, MAX_OUTSTANDING=2: back-to-back at full rate.
    cyc(1, "l2.c0", H, 32'h0, H, L, 32'h0,          L, L);
    cyc(1, "l2.c1", H, 32'h4, H, L, 32'h0,          L, H);
    cyc(1, "l2.c2", H, 32'h8, H, H, 32'h0000_0413, L, H);
    cyc(1, "l2.c3", H, 32'hC, H, H, 32'h0040_0493, L, H);
    cyc(1, "l2.c4", L, 32'h0, L, H, 32'h0000_0013, L, H);
    cyc(1, "l2.c5", L, 32'h0, L, H, 32'hCAFE_F00D, L, H);
    cyc(1, "l2.c6", L, 32'h0, L, L, 32'h0,          L, L);
    idle(5);

    // LATENCY=2, MAX_OUTSTANDING=1: grant returns in the retiring cycle.
    cyc(2, "m1.c0", H, 32'h0, H, L, 32'h0,          L, L);
    cyc(2, "m1.c1", H, 32'h4, L, L, 32'h0,          L, H);
    cyc(2, "m1.c2", H, 32'h4, H, H, 32'h0000_0413, L, H);
    cyc(2, "m1.c3", L, 32'h0, L, L, 32'h0,          L, H);
    cyc(2, "m1.c4", L, 32'h0, L, H, 32'h0040_0493, L, H);
    cyc(2, "m1.c5", L, 32'h0, L, L, 32'h0,          L, L);
    idle(5);

    // LATENCY=3: reset with two requests in flight drops both.
    cyc(3, "l3.c0", H, 32'h0, H, L, 32'h0, L, L);
    cyc(3, "l3.c1", H, 32'h4, H, L, 32'h0, L, H);
    rst_n = 1'b0;
    cyc(3, "l3.rst", H, 32'h8, L, L, 32'h0, L, L);
    rst_n = 1'b1;
    cyc(3, "l3.p0", H, 32'h8, H, L, 32'h0,          L, L);
    cyc(3, "l3.p1", L, 32'h0, L, L, 32'h0,          L, H);
    cyc(3, "l3.p2", L, 32'h0, L, L, 32'h0,          L, H);
    cyc(3, "l3.p3", L, 32'h0, L, H, 32'h0000_0013, L, H);
    cyc(3, "l3.p4", L, 32'h0, L, L, 32'h0,          L, L);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
